// File: rtl/cnn_mul_pkg.sv
// rtl/cnn_mul_pkg.sv - shared widths, product type and round-robin pick helper
package cnn_mul_pkg;

  localparam int DefaultDataWidth = 8;
  localparam int MaxReq = 32;

  typedef logic [2*DefaultDataWidth-1:0] prod_t;

  // First set bit of valid searching ptr, ptr+1, ... mod n; -1 when none set.
  function automatic int rr_grant(input logic [MaxReq-1:0] valid, input int ptr, input int n);
    logic [MaxReq-1:0] sh;
    int idx;
    rr_grant = -1;
    for (int k = MaxReq - 1; k >= 0; k--) begin
      if (k < n) begin
        idx = (ptr + k) % n;
        sh = valid >> idx;
        if (sh[0]) rr_grant = idx;
      end
    end
  endfunction

endpackage

// File: rtl/Mul.sv
// rtl/Mul.sv - combinational full-width unsigned multiplier
module Mul #(
  parameter int Width = 8
) (
  input  logic [Width-1:0]   a,
  input  logic [Width-1:0]   b,
  output logic [2*Width-1:0] p
);

  assign p = (2*Width)'(a) * (2*Width)'(b);

endmodule

// File: rtl/mul_share_arbiter.sv
// rtl/mul_share_arbiter.sv - round-robin shared multiplier with two-stage tagged pipeline
module mul_share_arbiter
  import cnn_mul_pkg::*;
#(
  parameter int DataWidth = DefaultDataWidth,
  parameter int NUM_REQ   = 4,
  parameter int IdWidth   = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DataWidth-1:0] req_m1,
  input  logic [NUM_REQ*DataWidth-1:0] req_m2,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [2*DataWidth-1:0]       res_p,
  output logic [IdWidth-1:0]           res_id
);

  logic                   s1_valid_q, s1_valid_d;
  logic [DataWidth-1:0]   s1_m1_q, s1_m1_d;
  logic [DataWidth-1:0]   s1_m2_q, s1_m2_d;
  logic [IdWidth-1:0]     s1_id_q, s1_id_d;
  logic                   s2_valid_q, s2_valid_d;
  logic [2*DataWidth-1:0] s2_p_q, s2_p_d;
  logic [IdWidth-1:0]     s2_id_q, s2_id_d;
  logic [IdWidth-1:0]     rr_ptr_q, rr_ptr_d;

  logic                   s1_adv, s2_adv, gnt;
  int                     gnt_idx;
  logic [DataWidth-1:0]   sel_m1, sel_m2;
  logic [2*DataWidth-1:0] prod;

  Mul #(.Width(DataWidth)) u_mul (
    .a(s1_m1_q),
    .b(s1_m2_q),
    .p(prod)
  );

  always_comb begin
    s2_adv    = !s2_valid_q || res_ready;
    s1_adv    = !s1_valid_q || s2_adv;
    gnt_idx   = rr_grant(MaxReq'(req_valid), int'(rr_ptr_q), NUM_REQ);
    // Reset gates the grant so nothing is handshaken while state is being cleared.
    gnt       = s1_adv && !rst && (gnt_idx >= 0);
    req_ready = '0;
    sel_m1    = '0;
    sel_m2    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == i) begin
        req_ready[i] = gnt;
        sel_m1       = req_m1[i*DataWidth +: DataWidth];
        sel_m2       = req_m2[i*DataWidth +: DataWidth];
      end
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_m1_d    = s1_m1_q;
    s1_m2_d    = s1_m2_q;
    s1_id_d    = s1_id_q;
    s2_valid_d = s2_valid_q;
    s2_p_d     = s2_p_q;
    s2_id_d    = s2_id_q;
    rr_ptr_d   = rr_ptr_q;
    if (s1_adv) begin
      s1_valid_d = gnt;
      if (gnt) begin
        s1_m1_d  = sel_m1;
        s1_m2_d  = sel_m2;
        s1_id_d  = IdWidth'(gnt_idx);
        rr_ptr_d = (gnt_idx == NUM_REQ - 1) ? '0 : IdWidth'(gnt_idx + 1);
      end
    end
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_p_d  = prod;
        s2_id_d = s1_id_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_m1_q    <= '0;
      s1_m2_q    <= '0;
      s1_id_q    <= '0;
      s2_valid_q <= 1'b0;
      s2_p_q     <= '0;
      s2_id_q    <= '0;
      rr_ptr_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_m1_q    <= s1_m1_d;
      s1_m2_q    <= s1_m2_d;
      s1_id_q    <= s1_id_d;
      s2_valid_q <= s2_valid_d;
      s2_p_q     <= s2_p_d;
      s2_id_q    <= s2_id_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  assign res_valid = s2_valid_q;
  assign res_p     = s2_p_q;
  assign res_id    = s2_id_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// tb/tb_mul_share_arbiter.sv - directed vector bench for the shared multiplier arbiter
module tb_mul_share_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_m1, req_m2;
  logic [NR-1:0]     req_ready;
  logic              res_valid;
  logic              res_ready;
  logic [2*DW-1:0]   res_p;
  logic [IW-1:0]     res_id;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int id;
    int m1;
    int m2;
    int exp_p;
  } vec_t;

  vec_t vecs[6];

  mul_share_arbiter #(.DataWidth(DW), .NUM_REQ(NR)) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_m1(req_m1),
    .req_m2(req_m2),
    .req_ready(req_ready),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_p(res_p),
    .res_id(res_id)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_m1[i*DW +: DW] = DW'(a);
    req_m2[i*DW +: DW] = DW'(b);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  function automatic int op1(input int i);
    return i + 3;
  endfunction

  function automatic int op2(input int i);
    return 7 * i + 5;
  endfunction

  task automatic load_all_ops();
    for (int i = 0; i < NR; i++) set_ops(i, op1(i), op2(i));
  endtask

  initial begin
    vecs[0] = '{id: 2, m1: 12,  m2: 11,  exp_p: 132};
    vecs[1] = '{id: 0, m1: 255, m2: 255, exp_p: 65025};
    vecs[2] = '{id: 1, m1: 0,   m2: 200, exp_p: 0};
    vecs[3] = '{id: 3, m1: 1,   m2: 255, exp_p: 255};
    vecs[4] = '{id: 2, m1: 128, m2: 2,   exp_p: 256};
    vecs[5] = '{id: 0, m1: 17,  m2: 15,  exp_p: 255};

    req_valid = '0;
    req_m1    = '0;
    req_m2    = '0;
    res_ready = 1'b1;

    // Reset values, with requests pending so req_ready gating is exercised.
    rst = 1'b1;
    req_valid = 4'hF;
    next_cycle();
    @(negedge clk);
    check("reset res_valid", int'(res_valid), 0);
    check("reset res_p", int'(res_p), 0);
    check("reset res_id", int'(res_id), 0);
    check("reset req_ready", int'(req_ready), 0);
    next_cycle();
    rst = 1'b0;
    req_valid = '0;

    // Single isolated requests: grant in cycle 0, result in cycle 2.
    for (int v = 0; v < 6; v++) begin
      set_ops(vecs[v].id, vecs[v].m1, vecs[v].m2);
      req_valid = NR'(1 << vecs[v].id);
      @(negedge clk);
      check($sformatf("vec%0d req_ready", v), int'(req_ready), 1 << vecs[v].id);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      check($sformatf("vec%0d res_valid c1", v), int'(res_valid), 0);
      next_cycle();
      @(negedge clk);
      check($sformatf("vec%0d res_valid", v), int'(res_valid), 1);
      check($sformatf("vec%0d res_p", v), int'(res_p), vecs[v].exp_p);
      check($sformatf("vec%0d res_id", v), int'(res_id), vecs[v].id);
      next_cycle();
    end

    // Round robin with all requesters valid and no backpressure.
    do_reset();
    load_all_ops();
    req_valid = 4'hF;
    res_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("rr c%0d grant", c), int'(req_ready), 1 << (c % NR));
      if (c >= 2) begin
        check($sformatf("rr c%0d res_valid", c), int'(res_valid), 1);
        check($sformatf("rr c%0d res_id", c), int'(res_id), (c - 2) % NR);
        check($sformatf("rr c%0d res_p", c), int'(res_p), op1((c - 2) % NR) * op2((c - 2) % NR));
      end
      next_cycle();
    end

    // Backpressure: two accepts fill S1/S2, then stall until res_ready returns.
    do_reset();
    load_all_ops();
    req_valid = 4'hF;
    res_ready = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c == 7) res_ready = 1'b1;
      @(negedge clk);
      if (c < 2) begin
        check($sformatf("bp c%0d grant", c), int'(req_ready), 1 << c);
      end else if (c < 7) begin
        check($sformatf("bp c%0d stall ready", c), int'(req_ready), 0);
        check($sformatf("bp c%0d hold valid", c), int'(res_valid), 1);
        check($sformatf("bp c%0d hold id", c), int'(res_id), 0);
        check($sformatf("bp c%0d hold p", c), int'(res_p), op1(0) * op2(0));
      end else begin
        check($sformatf("bp c%0d grant", c), int'(req_ready), 1 << ((c - 5) % NR));
        check($sformatf("bp c%0d res_valid", c), int'(res_valid), 1);
        check($sformatf("bp c%0d res_id", c), int'(res_id), c - 7);
        check($sformatf("bp c%0d res_p", c), int'(res_p), op1(c - 7) * op2(c - 7));
      end
      next_cycle();
    end

    // Sparse requesters with the pointer parked at 1.
    do_reset();
    load_all_ops();
    res_ready = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    check("sp c0 grant", int'(req_ready), 4'b0001);
    next_cycle();
    req_valid = 4'b1001;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("sp c%0d grant", c), int'(req_ready), (c % 2 == 1) ? 4'b1000 : 4'b0001);
      if (c >= 2) begin
        check($sformatf("sp c%0d res_id", c), int'(res_id), (c % 2 == 0) ? 0 : 3);
      end
      next_cycle();
    end

    // Reset while S1 and S2 both hold work.
    do_reset();
    load_all_ops();
    req_valid = 4'hF;
    res_ready = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("mr during rst ready", int'(req_ready), 0);
    next_cycle();
    rst = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    check("mr c0 res_valid", int'(res_valid), 0);
    check("mr c0 grant", int'(req_ready), 4'b0001);
    next_cycle();
    @(negedge clk);
    check("mr c1 res_valid", int'(res_valid), 0);
    next_cycle();
    @(negedge clk);
    check("mr c2 res_valid", int'(res_valid), 1);
    check("mr c2 res_id", int'(res_id), 0);
    check("mr c2 res_p", int'(res_p), op1(0) * op2(0));
    next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
